fp_multi_timer: RTL and testbench



---
 rtl/fp_multi_timer_if.sv | 11 +
 rtl/fp_multi_timer.sv | 146 ++++++++++++++
 tb/tb_fp_multi_timer.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_multi_timer_if.sv
// Avalon-MM register bus bundle shared by the timer (slave) and its host (master).
interface fp_multi_timer_if;
    logic [4:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/fp_multi_timer.sv
// NUM_CH independent prescaled down-counting interval timers behind one Avalon-MM slave,
// each with a snapshot register, one-shot/continuous mode and its own interrupt.
module fp_multi_timer #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = 49999
) (
    input  logic              clk,
    input  logic              reset_n,
    fp_multi_timer_if.slave   bus,
    output logic [NUM_CH-1:0] irq_vec,
    output logic              irq
);
    typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} chState_e;

    logic        wrStrobe;
    logic [2:0]  chIdx;
    logic [1:0]  regIdx;
    logic [31:0] wrData;
    logic        unusedWrBits;
    logic [31:0] rdArr [NUM_CH];
    logic [31:0] readData_d, readData_q;

    assign wrStrobe     = bus.chipselect && !bus.write_n;
    assign chIdx        = bus.address[4:2];
    assign regIdx       = bus.address[1:0];
    assign wrData       = bus.writedata;
    assign unusedWrBits = ^wrData;

    for (genvar i = 0; i < NUM_CH; i++) begin : gCh
        chState_e         state_q, state_d;
        logic             to_q, to_d, ito_q, ito_d, cont_q, cont_d;
        logic [7:0]       pre_q, pre_d, pcnt_q, pcnt_d;
        logic [CNT_W-1:0] period_q, period_d, cnt_q, cnt_d, snap_q, snap_d;
        logic             sel, running, tick, timeout;
        logic             wrStatus, wrCtrl, wrPeriod, wrSnap, startReq, stopReq;
        logic [31:0]      rdWord;

        assign sel      = wrStrobe && (chIdx == 3'(i));
        assign wrStatus = sel && (regIdx == 2'd0);
        assign wrCtrl   = sel && (regIdx == 2'd1);
        assign wrPeriod = sel && (regIdx == 2'd2);
        assign wrSnap   = sel && (regIdx == 2'd3);
        assign startReq = wrCtrl && wrData[2];
        assign stopReq  = wrCtrl && wrData[3];
        assign running  = (state_q == RUNNING);
        assign tick     = running && (pcnt_q == 8'd0);
        assign timeout  = tick && (cnt_q == '0);

        always_comb begin
            state_d  = state_q;
            to_d     = to_q;
            ito_d    = ito_q;
            cont_d   = cont_q;
            pre_d    = pre_q;
            pcnt_d   = pcnt_q;
            period_d = period_q;
            cnt_d    = cnt_q;
            snap_d   = snap_q;

            // START beats STOP in the same write; START while running is ignored
            case (state_q)
                STOPPED: if (startReq) state_d = RUNNING;
                RUNNING: if ((stopReq && !startReq) || wrPeriod || (timeout && !cont_q))
                             state_d = STOPPED;
                default: state_d = STOPPED;
            endcase

            if (wrCtrl) begin
                ito_d  = wrData[0];
                cont_d = wrData[1];
                pre_d  = wrData[15:8];
            end

            if (wrPeriod || (startReq && !running)) pcnt_d = 8'd0;
            else if (tick)                          pcnt_d = pre_q;
            else if (running)                       pcnt_d = pcnt_q - 8'd1;

            if (wrPeriod) begin
                period_d = wrData[CNT_W-1:0];
                cnt_d    = wrData[CNT_W-1:0];
            end else if (tick) begin
                cnt_d = (cnt_q == '0) ? period_q : cnt_q - CNT_W'(1);
            end

            // a timeout in the same cycle as a STATUS clear leaves TO set
            if (timeout)       to_d = 1'b1;
            else if (wrStatus) to_d = 1'b0;

            if (wrSnap) snap_d = cnt_q;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q  <= STOPPED;
                to_q     <= 1'b0;
                ito_q    <= 1'b0;
                cont_q   <= 1'b0;
                pre_q    <= 8'd0;
                pcnt_q   <= 8'd0;
                period_q <= CNT_W'(DEFAULT_PERIOD);
                cnt_q    <= CNT_W'(DEFAULT_PERIOD);
                snap_q   <= '0;
            end else begin
                state_q  <= state_d;
                to_q     <= to_d;
                ito_q    <= ito_d;
                cont_q   <= cont_d;
                pre_q    <= pre_d;
                pcnt_q   <= pcnt_d;
                period_q <= period_d;
                cnt_q    <= cnt_d;
                snap_q   <= snap_d;
            end
        end

        always_comb begin
            rdWord = '0;
            case (regIdx)
                2'd0:    rdWord = {30'd0, running, to_q};
                2'd1:    rdWord = {16'd0, pre_q, 6'd0, cont_q, ito_q};
                2'd2:    rdWord = 32'(period_q);
                default: rdWord = 32'(snap_q);
            endcase
        end

        assign rdArr[i]   = rdWord;
        assign irq_vec[i] = to_q && ito_q;
    end

    // unpopulated channel slots fall through to zero
    always_comb begin
        readData_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (chIdx == 3'(i)) readData_d = rdArr[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readData_q <= '0;
        else          readData_q <= readData_d;
    end

    assign bus.readdata = readData_q;
    assign irq          = |irq_vec;
endmodule

// File: tb/tb_fp_multi_timer.sv
// Directed and randomized checks of fp_multi_timer against a closed-form timing model
// that derives counter, RUN and TO from start time, period and prescale.
module tb_fp_multi_timer;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int DEF    = 49999;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b1;
    logic [NUM_CH-1:0] irq_vec;
    logic              irq;

    fp_multi_timer_if bus();

    fp_multi_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_PERIOD(DEF)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .irq_vec (irq_vec),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // per-channel model: a run segment is described by its start edge and starting count
    int mPer[NUM_CH], mCnt[NUM_CH], mPre[NUM_CH], mStart[NUM_CH], mC0[NUM_CH];
    int mSnap[NUM_CH], mLastTo[NUM_CH], mLastClear[NUM_CH];
    bit mRun[NUM_CH], mIto[NUM_CH], mCont[NUM_CH];

    function automatic int ticksBy(int ch, int e);
        return (e - mStart[ch] + mPre[ch]) / (mPre[ch] + 1);
    endfunction

    function automatic int cntAt(int ch, int e);
        int t;
        if (!mRun[ch]) return mCnt[ch];
        t = ticksBy(ch, e);
        if (t <= mC0[ch]) return mC0[ch] - t;
        return mPer[ch] - ((t - mC0[ch] - 1) % (mPer[ch] + 1));
    endfunction

    function automatic bit toAt(int ch);
        return (mLastTo[ch] >= 0) && (mLastTo[ch] >= mLastClear[ch]);
    endfunction

    function automatic logic [31:0] ctrlWord(int ch);
        return (32'(mPre[ch]) << 8) | (32'(mCont[ch]) << 1) | 32'(mIto[ch]);
    endfunction

    task automatic settle(input int ch, input int e);
        int t, k, j;
        if (!mRun[ch]) return;
        t = ticksBy(ch, e);
        if (t <= mC0[ch]) return;
        if (!mCont[ch]) begin
            mLastTo[ch] = mStart[ch] + mC0[ch] * (mPre[ch] + 1) + 1;
            mRun[ch]    = 1'b0;
            mCnt[ch]    = mPer[ch];
        end else begin
            k = 1 + (t - mC0[ch] - 1) / (mPer[ch] + 1);
            j = mC0[ch] + 1 + (k - 1) * (mPer[ch] + 1);
            mLastTo[ch] = mStart[ch] + (j - 1) * (mPre[ch] + 1) + 1;
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NUM_CH; i++) begin
            mPer[i] = DEF; mCnt[i] = DEF; mPre[i] = 0; mStart[i] = 0; mC0[i] = 0;
            mSnap[i] = 0; mLastTo[i] = -1; mLastClear[i] = -1;
            mRun[i] = 1'b0; mIto[i] = 1'b0; mCont[i] = 1'b0;
        end
    endtask

    task automatic modelWrite(input int ch, input int rg, input logic [31:0] d, input int w);
        bit wasRun;
        if (ch >= NUM_CH) return;
        case (rg)
            0: begin
                settle(ch, w);
                mLastClear[ch] = w;
            end
            1: begin
                settle(ch, w - 1);
                wasRun = mRun[ch];
                settle(ch, w);
                if (d[2]) begin
                    if (!wasRun) begin
                        mRun[ch] = 1'b1; mStart[ch] = w; mC0[ch] = mCnt[ch];
                    end
                end else if (d[3] && mRun[ch]) begin
                    mCnt[ch] = cntAt(ch, w);
                    mRun[ch] = 1'b0;
                end
                mIto[ch] = d[0]; mCont[ch] = d[1]; mPre[ch] = int'(d[15:8]);
            end
            2: begin
                settle(ch, w);
                mPer[ch] = int'(d); mCnt[ch] = int'(d); mRun[ch] = 1'b0;
            end
            default: begin
                settle(ch, w - 1);
                mSnap[ch] = cntAt(ch, w - 1);
            end
        endcase
    endtask

    task automatic modelWord(input int ch, input int rg, input int e, output logic [31:0] w);
        w = '0;
        if (ch >= NUM_CH) return;
        settle(ch, e);
        case (rg)
            0:       w = {30'd0, mRun[ch], toAt(ch)};
            1:       w = ctrlWord(ch);
            2:       w = 32'(mPer[ch]);
            default: w = 32'(mSnap[ch]);
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        cyc = cyc + 1;
        #1;
    endtask

    task automatic idle(input int n);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        repeat (n) tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int ch, input int rg, input logic [31:0] d);
        bus.address    = {3'(ch), 2'(rg)};
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        modelWrite(ch, rg, d, cyc + 1);
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic readCheck(input string tag, input int ch, input int rg, output logic [31:0] obs);
        logic [31:0] exp;
        bus.address    = {3'(ch), 2'(rg)};
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        modelWord(ch, rg, cyc, exp);
        tick();
        obs = bus.readdata;
        bus.chipselect = 1'b0;
        checkOutput(tag, obs, exp);
    endtask

    task automatic checkIrq(input string tag);
        logic [NUM_CH-1:0] e;
        for (int i = 0; i < NUM_CH; i++) begin
            settle(i, cyc);
            e[i] = toAt(i) && mIto[i];
        end
        checkOutput({tag, "_vec"}, 32'(irq_vec), 32'(e));
        checkOutput(tag, 32'(irq), 32'(|e));
    endtask

    task automatic quiesce(input int ch);
        settle(ch, cyc);
        if (mRun[ch]) applyStimulus(ch, 1, ctrlWord(ch) | 32'h8);
        applyStimulus(ch, 1, 32'h0);
        applyStimulus(ch, 0, 32'h0);
    endtask

    initial begin
        logic [31:0] obs, prev, d;
        int          w, op, ch, rg;

        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        modelReset();
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rst_readdata", bus.readdata, 32'h0);
        checkOutput("rst_irq", 32'(irq), 32'h0);
        checkOutput("rst_irq_vec", 32'(irq_vec), 32'h0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        $display("[TB] reset values");
        readCheck("rst_period0", 0, 2, obs);
        checkOutput("rst_period0_const", obs, 32'h0000C34F);
        readCheck("rst_status0", 0, 0, obs);
        readCheck("rst_ctrl0", 0, 1, obs);
        readCheck("rst_snap0", 0, 3, obs);
        readCheck("rst_ch5", 5, 2, obs);
        checkOutput("rst_ch5_const", obs, 32'h0);

        $display("[TB] one-shot on ch1");
        applyStimulus(1, 2, 32'd9);
        applyStimulus(1, 1, 32'h1);
        applyStimulus(1, 1, 32'h5);
        w = cyc;
        idle(9);
        checkOutput("os_irq_early", 32'(irq), 32'h0);
        idle(1);
        checkOutput("os_irq_at10", 32'(irq), 32'h1);
        checkIrq("os_irq_model");
        readCheck("os_status", 1, 0, obs);
        checkOutput("os_status_const", obs, 32'h1);
        applyStimulus(1, 3, 32'h0);
        readCheck("os_snap", 1, 3, obs);
        checkOutput("os_snap_const", obs, 32'd9);
        applyStimulus(1, 0, 32'h0);
        checkOutput("os_irq_cleared", 32'(irq), 32'h0);

        $display("[TB] continuous with prescale on ch2");
        applyStimulus(2, 2, 32'd4);
        applyStimulus(2, 1, 32'h303);
        applyStimulus(2, 1, 32'h307);
        w = cyc;
        idle(16);
        checkOutput("cont_vec_early", 32'(irq_vec), 32'h0);
        idle(1);
        checkOutput("cont_vec_first", 32'(irq_vec), 32'h4);
        checkIrq("cont_first_model");
        applyStimulus(2, 0, 32'h0);
        checkOutput("cont_cleared", 32'(irq), 32'h0);
        idle(w + 36 - cyc);
        checkOutput("cont_vec_before2", 32'(irq_vec), 32'h0);
        idle(1);
        checkOutput("cont_vec_second", 32'(irq_vec), 32'h4);
        checkIrq("cont_second_model");
        quiesce(2);

        $display("[TB] snapshot, stop and period write on ch0");
        applyStimulus(0, 2, 32'd100);
        applyStimulus(0, 1, 32'h4);
        idle(29);
        applyStimulus(0, 3, 32'h0);
        readCheck("snap_run", 0, 3, obs);
        checkOutput("snap_run_const", obs, 32'd71);
        applyStimulus(0, 1, 32'h8);
        applyStimulus(0, 3, 32'h0);
        readCheck("snap_stop", 0, 3, prev);
        idle(5);
        applyStimulus(0, 3, 32'h0);
        readCheck("snap_frozen", 0, 3, obs);
        checkOutput("snap_frozen_same", obs, prev);
        applyStimulus(0, 1, 32'h4);
        idle(7);
        applyStimulus(0, 2, 32'd50);
        readCheck("per_status", 0, 0, obs);
        applyStimulus(0, 3, 32'h0);
        readCheck("per_snap", 0, 3, obs);
        checkOutput("per_snap_const", obs, 32'd50);

        $display("[TB] clear colliding with timeout on ch3");
        applyStimulus(3, 2, 32'd2);
        applyStimulus(3, 1, 32'h4);
        idle(2);
        applyStimulus(3, 0, 32'h0);
        readCheck("coll_status", 3, 0, obs);
        checkOutput("coll_status_const", obs, 32'h1);
        applyStimulus(3, 1, 32'hC);
        readCheck("startstop_status", 3, 0, obs);
        checkOutput("startstop_const", obs, 32'h3);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 150; it++) begin
            op = int'($urandom_range(0, 9));
            ch = ($urandom_range(0, 5) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            rg = int'($urandom_range(0, 3));
            case (op)
                0, 1, 2, 3: readCheck("rnd_read", ch, rg, obs);
                4: applyStimulus(ch, 0, $urandom);
                5: begin
                    d = (32'($urandom_range(0, 3)) << 8) | 32'($urandom_range(0, 3));
                    if (ch < NUM_CH) begin
                        settle(ch, cyc);
                        if (mRun[ch]) d = ctrlWord(ch);
                    end
                    d = d | ($urandom & 32'hFFFF_00F0) | (32'($urandom_range(0, 3)) << 2);
                    applyStimulus(ch, 1, d);
                end
                6: applyStimulus(ch, 2, 32'($urandom_range(0, 15)));
                7: applyStimulus(ch, 3, $urandom);
                8: idle(int'($urandom_range(1, 25)));
                default: idle(1);
            endcase
            checkIrq("rnd_irq");
        end

        $display("[TB] channel independence and async reset");
        for (int i = 0; i < NUM_CH; i++) quiesce(i);
        applyStimulus(0, 2, 32'd5);
        applyStimulus(3, 2, 32'd20);
        applyStimulus(0, 1, 32'h1);
        applyStimulus(3, 1, 32'h1);
        applyStimulus(0, 1, 32'h5);
        applyStimulus(3, 1, 32'h5);
        idle(5);
        checkOutput("ind_vec", 32'(irq_vec), 32'h1);
        checkOutput("ind_irq", 32'(irq), 32'h1);
        checkIrq("ind_model");
        bus.address = {3'd0, 2'd2};
        idle(4);
        checkOutput("ind_readdata_live", bus.readdata, 32'd5);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("arst_readdata", bus.readdata, 32'h0);
        checkOutput("arst_irq", 32'(irq), 32'h0);
        checkOutput("arst_irq_vec", 32'(irq_vec), 32'h0);
        tick();
        reset_n = 1'b1;
        modelReset();
        tick();
        readCheck("arst_status3", 3, 0, obs);
        readCheck("arst_period0", 0, 2, obs);
        checkOutput("arst_period0_const", obs, 32'h0000C34F);
        applyStimulus(3, 3, 32'h0);
        readCheck("arst_snap3", 3, 3, obs);
        checkOutput("arst_snap3_const", obs, 32'd49999);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
